// File: rtl/gaussian_pkg.sv
// Shared types and helpers for the streaming Gaussian blur.
// Optional build macro GAUSS_ROUND_EN is consumed by gaussian_stream_top.
package gaussian_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam int LAT = 3;

    // Running product stays integral: r holds C(n,i) before each step.
    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic int shift_amt(input int k);
        return 2 * (k - 1);
    endfunction

    function automatic int acc_width(input int bits, input int k);
        return bits + shift_amt(k);
    endfunction

    localparam int SHIFT_K7 = shift_amt(7);
    localparam int ACC_W_8B_K7 = acc_width(8, 7);
endpackage

// File: rtl/gaussian_linebuf.sv
// K-1 row line buffer plus KxK window; row 0 of the window is the oldest line.
module gaussian_linebuf
    import gaussian_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int K     = 7,
    parameter int MAX_W = 640,
    parameter int AW    = $clog2(MAX_W)
) (
    input  logic                  clk,
    input  logic                  stall,
    input  logic                  push,
    input  logic [AW-1:0]         addr,
    input  logic [BITS-1:0]       pix,
    output logic [K*K*BITS-1:0]   win
);
    logic [BITS-1:0] mem [K-1][MAX_W];
    logic [K-1:0][BITS-1:0] col;
    logic [K-1:0][K-1:0][BITS-1:0] win_q, win_d;
    logic shift_en;

    assign shift_en = push && !stall;
    assign win = win_q;

    always_comb begin
        for (int r = 0; r < K - 1; r++) col[r] = mem[r][addr];
        col[K-1] = pix;
    end

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][K-1] = col[r];
            end
        end
    end

    // Each column slot ages by one row per accept at its x address.
    always_ff @(posedge clk) begin
        win_q <= win_d;
        if (shift_en) begin
            for (int j = 0; j < K - 2; j++) mem[j][addr] <= col[j+1];
            mem[K-2][addr] <= pix;
        end
    end
endmodule

// File: rtl/gaussian_stream_top.sv
// Streaming KxK binomial blur, valid/ready in and out, valid-region crop.
// Define GAUSS_ROUND_EN to round half up instead of truncating.
module gaussian_stream_top
    import gaussian_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int K     = 7,
    parameter int MAX_W = 640,
    parameter int DIM_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic [BITS-1:0]  pix_in,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    output logic [BITS-1:0]  pix_out,
    output logic             pix_out_valid,
    input  logic             pix_out_ready,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);
    localparam int SHIFT = shift_amt(K);
    localparam int ACC_W = acc_width(BITS, K);
    localparam int RS_W  = BITS + K - 1;
    localparam int AW    = $clog2(MAX_W);
    localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);
    localparam logic [DIM_W-1:0] K_D    = DIM_W'(K);
    localparam logic [DIM_W-1:0] KM1    = DIM_W'(K - 1);
    localparam logic [DIM_W-1:0] MAXW_D = DIM_W'(MAX_W);

    state_t state_q, state_d;
    logic [DIM_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [LAT:1] vld_q, vld_d;
    logic [LAT:0] vld_pipe;
    logic [K-1:0][RS_W-1:0] row_q, row_d;
    logic [BITS-1:0] pix_out_q, pix_out_d;
    logic busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic en, stall, acc, last_px;
    logic [K*K*BITS-1:0] win;
    logic [RS_W-1:0] rs_v;
    logic [ACC_W-1:0] acc_v;

    assign en           = !(vld_q[LAT] && !pix_out_ready);
    assign stall        = !en;
    assign pix_in_ready = (state_q == S_RUN) && en;
    assign acc          = pix_in_valid && pix_in_ready;
    assign last_px      = (x_q == w_q - ONE) && (y_q == h_q - ONE);
    assign vld_pipe     = {vld_q, acc && (x_q >= KM1) && (y_q >= KM1)};

    assign pix_out       = pix_out_q;
    assign pix_out_valid = vld_q[LAT];
    assign busy          = busy_q;
    assign done          = done_q;
    assign cfg_err       = cfg_err_q;

    gaussian_linebuf #(.BITS(BITS), .K(K), .MAX_W(MAX_W), .AW(AW)) u_linebuf (
        .clk   (clk),
        .stall (stall),
        .push  (acc),
        .addr  (x_q[AW-1:0]),
        .pix   (pix_in),
        .win   (win)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                w_d = img_w;
                h_d = img_h;
                x_d = '0;
                y_d = '0;
                if (img_w >= K_D && img_w <= MAXW_D && img_h >= K_D) begin
                    state_d = S_RUN;
                end else begin
                    state_d   = S_FIN;
                    done_d    = 1'b1;
                    cfg_err_d = 1'b1;
                end
            end
            S_RUN: if (acc) begin
                if (x_q == w_q - ONE) begin
                    x_d = '0;
                    y_d = y_q + ONE;
                end else begin
                    x_d = x_q + ONE;
                end
                if (last_px) state_d = S_DRAIN;
            end
            // Leave as the final output handshakes, so done lands one cycle later.
            S_DRAIN: if (vld_q[LAT-1:1] == '0 && (!vld_q[LAT] || pix_out_ready)) begin
                state_d = S_FIN;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    always_comb begin
        vld_d     = vld_q;
        row_d     = row_q;
        pix_out_d = pix_out_q;
        rs_v      = '0;
        acc_v     = '0;
        if (en) begin
            vld_d = vld_pipe[LAT-1:0];
            for (int r = 0; r < K; r++) begin
                rs_v = '0;
                for (int c = 0; c < K; c++)
                    rs_v = rs_v + RS_W'(binom(K - 1, c)) * RS_W'(win[(r*K+c)*BITS +: BITS]);
                row_d[r] = rs_v;
            end
`ifdef GAUSS_ROUND_EN
            acc_v = ACC_W'(1) << (SHIFT - 1);
`else
            acc_v = '0;
`endif
            for (int r = 0; r < K; r++)
                acc_v = acc_v + ACC_W'(binom(K - 1, r)) * ACC_W'(row_q[r]);
            if (vld_q[LAT-1]) pix_out_d = BITS'(acc_v >> SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            vld_q     <= '0;
            row_q     <= '0;
            pix_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            vld_q     <= vld_d;
            row_q     <= row_d;
            pix_out_q <= pix_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end
endmodule

// File: tb/tb_gaussian_stream_top.sv
// Scoreboard bench for gaussian_stream_top (K=3): random frames vs. a direct convolution model.
module tb_gaussian_stream_top;
    localparam int KK   = 3;
    localparam int MAXW = 640;
    localparam int DEN  = 1 << (2 * (KK - 1));

    logic clk = 0, rst = 1, start = 0;
    logic [10:0] img_w = 0, img_h = 0;
    logic [7:0] pix_in = 0;
    logic pix_in_valid = 0, pix_out_ready = 1;
    logic pix_in_ready, pix_out_valid, busy, done, cfg_err;
    logic [7:0] pix_out;

    gaussian_stream_top #(.BITS(8), .K(KK), .MAX_W(MAXW), .DIM_W(11)) dut (
        .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
        .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_err = 0;
    int exp_q[$], got_q[$], pix_q[$];
    int wt[KK];
    int rdy_pct = 100, gap_pct = 0;
    int first_acc, last_acc, win_acc, first_out, last_hs, n_out;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Direct 2-D weighted average over the window whose bottom-right is (x,y).
    function automatic int ref_out(input int w, input int x, input int y);
        int s = 0;
        for (int i = 0; i < KK; i++)
            for (int j = 0; j < KK; j++)
                s += wt[i] * wt[j] * pix_q[(y - KK + 1 + i) * w + (x - KK + 1 + j)];
`ifdef GAUSS_ROUND_EN
        s += DEN / 2;
`endif
        return s / DEN;
    endfunction

    task automatic make_frame(input int w, input int h, input int kind, input int val);
        pix_q.delete();
        exp_q.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                case (kind)
                    0: pix_q.push_back(val);
                    1: pix_q.push_back((x == 2 && y == 2) ? 255 : 0);
                    2: pix_q.push_back((x * 13 + y * 29) % 256);
                    default: pix_q.push_back(int'($urandom_range(0, 255)));
                endcase
        for (int y = KK - 1; y < h; y++)
            for (int x = KK - 1; x < w; x++) exp_q.push_back(ref_out(w, x, y));
    endtask

    task automatic monitor();
        bit stall_prev = 0;
        logic [7:0] prev = 0;
        int e;
        forever begin
            @(negedge clk);
            if (rst) stall_prev = 0;
            else begin
                if (stall_prev) begin
                    n_cmp++;
                    if (!pix_out_valid || pix_out !== prev) begin
                        n_err++;
                        $display("FAIL stall_hold: got valid=%0b pix=%0d, held pix %0d", pix_out_valid, pix_out, prev);
                    end
                end
                if (pix_out_valid && pix_out_ready) begin
                    n_out++;
                    if (n_out == 1) first_out = cyc;
                    last_hs = cyc;
                    got_q.push_back(int'(pix_out));
                    if (exp_q.size() == 0) check("extra_output", int'(pix_out), -1);
                    else begin
                        e = exp_q.pop_front();
                        check("pix_out", int'(pix_out), e);
                    end
                end
                stall_prev = pix_out_valid && !pix_out_ready;
                prev = pix_out;
            end
        end
    endtask

    task automatic sink_drv();
        forever begin
            @(posedge clk); #1;
            pix_out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic start_frame(input int w, input int h);
        @(posedge clk); #1;
        start = 1; img_w = 11'(w); img_h = 11'(h);
        @(posedge clk); #1;
        start = 0; img_w = 11'($urandom); img_h = 11'($urandom);
    endtask

    task automatic drive(input int w, input int n);
        int i = 0, tmo = 0;
        while (i < n && tmo < 20000) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 99) < gap_pct) pix_in_valid = 0;
            else begin
                pix_in_valid = 1;
                pix_in = 8'(pix_q[i]);
            end
            @(negedge clk);
            if (pix_in_valid && pix_in_ready) begin
                if (i == 0) first_acc = cyc;
                if (i == (KK - 1) * w + KK - 1) win_acc = cyc;
                last_acc = cyc;
                i++;
            end
            tmo++;
        end
        @(posedge clk); #1;
        pix_in_valid = 0;
        if (i < n) check("input_timeout", i, n);
    endtask

    task automatic wait_done(input int bound, output int dcyc, output int cerr);
        dcyc = -1; cerr = -1;
        for (int t = 0; t < bound; t++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc; cerr = int'(cfg_err);
                break;
            end
        end
    endtask

    task automatic run_frame(input int w, input int h, input int kind, input int val,
                             input int rdy, input int gap);
        int dcyc, cerr;
        rdy_pct = rdy; gap_pct = gap;
        make_frame(w, h, kind, val);
        n_out = 0; got_q.delete();
        start_frame(w, h);
        @(negedge clk);
        check("busy_run", int'(busy), 1);
        drive(w, w * h);
        wait_done(3000, dcyc, cerr);
        check("done_seen", int'(dcyc >= 0), 1);
        check("cfg_err_ok", cerr, 0);
        check("done_gap", dcyc - last_hs, 1);
        check("n_out", n_out, (w - KK + 1) * (h - KK + 1));
        check("exp_left", exp_q.size(), 0);
        if (rdy == 100) check("latency", first_out - win_acc, 3);
        @(negedge clk);
        check("done_pulse", int'(done) + int'(busy), 0);
    endtask

    int cfg_tab[3][2] = '{'{2, 6}, '{641, 4}, '{5, 2}};

    initial begin
        int dcyc, cerr, bad;
        wt[0] = 1;
        for (int j = 1; j < KK; j++) wt[j] = 0;
        for (int n = 1; n < KK; n++)
            for (int j = n; j >= 1; j--) wt[j] += wt[j-1];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(pix_in_ready), 0);
        check("rst_pix_out", int'(pix_out), 0);
        check("rst_valid", int'(pix_out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        @(posedge clk); #1 rst = 0;
        fork
            monitor();
            sink_drv();
        join_none

        run_frame(8, 6, 0, 100, 100, 0);
        run_frame(5, 5, 1, 0, 100, 0);
`ifdef GAUSS_ROUND_EN
        check("impulse_center", got_q[4], 64);
        check("impulse_corner", got_q[0], 16);
`else
        check("impulse_center", got_q[4], 63);
        check("impulse_corner", got_q[0], 15);
`endif
        run_frame(16, 10, 2, 0, 50, 20);
        run_frame(12, 9, 3, 0, 70, 30);

        foreach (cfg_tab[k]) begin
            pix_in_valid = 1; pix_in = 8'hAA;
            start_frame(cfg_tab[k][0], cfg_tab[k][1]);
            bad = 0; dcyc = -1; cerr = -1;
            for (int t = 0; t < 5; t++) begin
                @(negedge clk);
                if (pix_in_ready || busy) bad = 1;
                if (done && dcyc < 0) begin dcyc = t; cerr = int'(cfg_err); end
            end
            pix_in_valid = 0;
            check("cfg_no_ready", bad, 0);
            check("cfg_done_soon", int'(dcyc >= 0 && dcyc <= 1), 1);
            check("cfg_err_set", cerr, 1);
        end

        run_frame(MAXW, KK, 3, 0, 100, 0);
        check("throughput", last_acc - first_acc, MAXW * KK - 1);

        rdy_pct = 60; gap_pct = 10;
        make_frame(10, 8, 3, 0);
        start_frame(10, 8);
        drive(10, 45);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        exp_q.delete();
        bad = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (done || pix_out_valid || busy || pix_in_ready) bad = 1;
        end
        check("rst_quiet", bad, 0);
        run_frame(8, 6, 0, 50, 60, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
